presc_gen: RTL

PRESC_GEN -- requirements
Module: presc_gen

---
 rtl/presc_gen.sv | 137 +++++++++++++
 1 files changed

// File: rtl/presc_gen.sv
`default_nettype none
// ============================================================================
// Module   : presc_gen
// Brief    : Programmable prescaler with free-running / one-shot modes and a
//            double-buffered divisor; optional mid-period pulse when
//            PRESC_GEN_HALF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module presc_gen #(
    parameter int W       = 4,
    parameter int DIV_RST = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         mode,
    input  logic         start,
    input  logic [W-1:0] div_in,
    input  logic         div_ld,
    output logic [W-1:0] Qount,
    output logic         strb,
    output logic         busy
`ifdef PRESC_GEN_HALF_EN
    ,
    output logic         strb_half
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [W-1:0] c_DIV_RST = W'(DIV_RST);
    localparam logic [W-1:0] c_ONE     = W'(1);

    // Divisors are held raw: a stored 0 means 2^W, so (div - 1) in W bits
    // is always the terminal count.
    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_count;
    logic [W-1:0]   w_count_nxt;
    logic           r_strb;
    logic           w_strb_nxt;
    logic [W-1:0]   r_div_act;
    logic [W-1:0]   w_div_act_nxt;
    logic [W-1:0]   r_div_pend;
    logic [W-1:0]   w_div_pend_nxt;
    logic [W-1:0]   w_last;
    logic [W-1:0]   w_inc;
    logic           w_wrap;

    assign w_last = r_div_act - c_ONE;
    assign w_inc  = r_count + c_ONE;
    assign w_wrap = (r_count == w_last);

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_strb_nxt     = 1'b0;
        w_div_act_nxt  = r_div_act;
        w_div_pend_nxt = div_ld ? div_in : r_div_pend;
        case (r_state)
            ST_IDLE: begin
                if (div_ld) begin
                    w_div_act_nxt = div_in;
                end
                if (en && (!mode || start)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (en) begin
                    if (w_wrap) begin
                        // A load on the wrap edge wins over the older pending value.
                        w_count_nxt   = '0;
                        w_strb_nxt    = 1'b1;
                        w_div_act_nxt = w_div_pend_nxt;
                        if (mode) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_count_nxt = w_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_strb     <= 1'b0;
            r_div_act  <= c_DIV_RST;
            r_div_pend <= c_DIV_RST;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_strb     <= w_strb_nxt;
            r_div_act  <= w_div_act_nxt;
            r_div_pend <= w_div_pend_nxt;
        end
    end

    assign Qount = r_count;
    assign strb  = r_strb;
    assign busy  = (r_state == ST_RUN);

`ifdef PRESC_GEN_HALF_EN
    logic [W:0] w_act_full;
    logic [W:0] w_half_pt;
    logic       w_half_hit;
    logic       r_strb_half;

    // Half point is floor(div/2); for div=1 it is 0, which an increment never reaches.
    assign w_act_full = {(r_div_act == '0), r_div_act};
    assign w_half_pt  = w_act_full >> 1;
    assign w_half_hit = (r_state == ST_RUN) && en && !w_wrap &&
                        ({1'b0, w_inc} == w_half_pt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_strb_half <= 1'b0;
        end else begin
            r_strb_half <= w_half_hit;
        end
    end

    assign strb_half = r_strb_half;
`endif

endmodule
`default_nettype wire
